// File: rtl/pe_fill_sched_pkg.sv
// Shared types for the PE scratchpad fill scheduler: FSM state encoding and
// a state-class helper.
package pe_fill_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_FILT  = 3'd1,
    ST_LOAD_IFMAP = 3'd2,
    ST_COMPUTE    = 3'd3,
    ST_SLIDE      = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  // Both the initial window fill and the per-window slide pull from the ifmap buffer.
  function automatic logic is_ifmap_fill(input state_e s);
    return (s == ST_LOAD_IFMAP) || (s == ST_SLIDE);
  endfunction

endpackage

// File: rtl/pe_fill_scheduler_if.sv
// Handshake bundle between the fill scheduler and its read buffers, pads and
// compute unit. The master side is the scheduler.
interface pe_fill_scheduler_if #(
  parameter int FILT_LEN = 4,
  parameter int WIN_W    = 8
);
  localparam int AW = $clog2(FILT_LEN);

  logic             chip_en;
  logic             start;
  logic [WIN_W-1:0] num_windows;
  logic             filt_buf_valid;
  logic             filt_buf_read_enable;
  logic             filt_pad_wen;
  logic [AW-1:0]    filt_pad_waddr;
  logic             ifmap_buf_valid;
  logic             ifmap_buf_read_enable;
  logic             ifmap_pad_wen;
  logic [AW-1:0]    ifmap_pad_waddr;
  logic [AW-1:0]    window_base;
  logic             compute_start;
  logic             compute_done;
  logic             compute_busy;
  logic             busy;
  logic             done;

  modport master (
    input  chip_en, start, num_windows, filt_buf_valid, ifmap_buf_valid, compute_done,
    output filt_buf_read_enable, filt_pad_wen, filt_pad_waddr,
    output ifmap_buf_read_enable, ifmap_pad_wen, ifmap_pad_waddr,
    output window_base, compute_start, compute_busy, busy, done
  );

  modport slave (
    output chip_en, start, num_windows, filt_buf_valid, ifmap_buf_valid, compute_done,
    input  filt_buf_read_enable, filt_pad_wen, filt_pad_waddr,
    input  ifmap_buf_read_enable, ifmap_pad_wen, ifmap_pad_waddr,
    input  window_base, compute_start, compute_busy, busy, done
  );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-MOD up-counter with synchronous clear; wrap flags the enabled step
// from MOD-1 back to 0. Wrap is explicit, so MOD need not be a power of two.
module wrap_counter #(
  parameter int MOD = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] value_d;
  logic [W-1:0] value_q;

  assign wrap  = en && (value_q == W'(MOD - 1));
  assign value = value_q;

  // next count; clear dominates so a state change always restarts from zero
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (en) begin
      value_d = wrap ? '0 : value_q + W'(1);
    end else begin
      value_d = value_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/pe_fill_scheduler.sv
// Scratchpad load sequencer for one PE running a 1-D convolution: filter pad
// once per job, ifmap pad as a circular window slid by STRIDE per output.
module pe_fill_scheduler
  import pe_fill_sched_pkg::*;
#(
  parameter int FILT_LEN = 4,
  parameter int STRIDE   = 1,
  parameter int WIN_W    = 8
) (
  input logic                  clk,
  input logic                  rst,
  pe_fill_scheduler_if.master  bus
);

  localparam int AW = $clog2(FILT_LEN);

  state_e           state_d, state_q;
  logic [WIN_W-1:0] win_left_d, win_left_q;
  logic             compute_start_d, compute_start_q;
  logic             compute_busy_d, compute_busy_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;

  logic             filt_xfer, ifmap_xfer, start_job, cnt_clr, cnt_wrap;
  logic             filt_wrap, ifmap_wrap, unused_ptr_wraps;
  logic [AW-1:0]    filt_ptr, ifmap_ptr, xfer_cnt;

  // A transfer is a pop and a pad write in the same cycle; nothing moves with chip_en low.
  assign filt_xfer  = (state_q == ST_LOAD_FILT) && bus.chip_en && bus.filt_buf_valid;
  assign ifmap_xfer = is_ifmap_fill(state_q) && bus.chip_en && bus.ifmap_buf_valid;
  assign start_job  = (state_q == ST_IDLE) && bus.start;
  assign cnt_clr    = (state_d != state_q);

  // Pointer wraps coincide with the transfer counter's in the load states.
  assign unused_ptr_wraps = filt_wrap | ifmap_wrap;

  wrap_counter #(.MOD(FILT_LEN), .W(AW)) u_filt_ptr (
    .clk(clk), .rst(rst), .en(filt_xfer), .clr(start_job),
    .value(filt_ptr), .wrap(filt_wrap)
  );

  wrap_counter #(.MOD(FILT_LEN), .W(AW)) u_ifmap_ptr (
    .clk(clk), .rst(rst), .en(ifmap_xfer), .clr(start_job),
    .value(ifmap_ptr), .wrap(ifmap_wrap)
  );

  wrap_counter #(.MOD(FILT_LEN), .W(AW)) u_xfer_cnt (
    .clk(clk), .rst(rst), .en(filt_xfer | ifmap_xfer), .clr(cnt_clr),
    .value(xfer_cnt), .wrap(cnt_wrap)
  );

  // next state, window bookkeeping and next values of the registered status outputs
  always_comb begin
    state_d    = state_q;
    win_left_d = win_left_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          win_left_d = bus.num_windows;
          state_d    = (bus.num_windows == '0) ? ST_DONE : ST_LOAD_FILT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_FILT: begin
        if (filt_xfer && cnt_wrap) state_d = ST_LOAD_IFMAP;
        else                       state_d = ST_LOAD_FILT;
      end
      ST_LOAD_IFMAP: begin
        if (ifmap_xfer && cnt_wrap) state_d = ST_COMPUTE;
        else                        state_d = ST_LOAD_IFMAP;
      end
      ST_COMPUTE: begin
        if (bus.compute_done) begin
          win_left_d = win_left_q - WIN_W'(1);
          state_d    = (win_left_q == WIN_W'(1)) ? ST_DONE : ST_SLIDE;
        end else begin
          state_d = ST_COMPUTE;
        end
      end
      ST_SLIDE: begin
        if (ifmap_xfer && (xfer_cnt == AW'(STRIDE - 1))) state_d = ST_COMPUTE;
        else                                             state_d = ST_SLIDE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    compute_start_d = (state_d == ST_COMPUTE) && (state_q != ST_COMPUTE);
    compute_busy_d  = (state_d == ST_COMPUTE);
    busy_d          = (state_d != ST_IDLE);
    done_d          = (state_d == ST_DONE);
  end

  // FSM state, remaining windows and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      win_left_q      <= '0;
      compute_start_q <= 1'b0;
      compute_busy_q  <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      win_left_q      <= win_left_d;
      compute_start_q <= compute_start_d;
      compute_busy_q  <= compute_busy_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign bus.filt_buf_read_enable  = filt_xfer;
  assign bus.filt_pad_wen          = filt_xfer;
  assign bus.filt_pad_waddr        = filt_ptr;
  assign bus.ifmap_buf_read_enable = ifmap_xfer;
  assign bus.ifmap_pad_wen         = ifmap_xfer;
  assign bus.ifmap_pad_waddr       = ifmap_ptr;
  assign bus.window_base           = compute_busy_q ? ifmap_ptr : '0;
  assign bus.compute_start         = compute_start_q;
  assign bus.compute_busy          = compute_busy_q;
  assign bus.busy                  = busy_q;
  assign bus.done                  = done_q;

endmodule

// File: tb/tb_pe_fill_scheduler.sv
// Bench for pe_fill_scheduler: two instances (STRIDE 1 and 2) share stimulus;
// a job-plan model predicts every cycle, literal sequences pin the model.
module tb_pe_fill_scheduler;

  localparam int FL   = 4;
  localparam int WW   = 8;
  localparam int AW   = 2;
  localparam int PMAX = 32;

  typedef enum int {K_FILT, K_IFM, K_CMP, K_DONE} kind_e;
  typedef struct {
    kind_e kind;
    int    addr;
    bit    started;
  } item_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          chip_en = 1'b0, start = 1'b0, filt_valid = 1'b0, ifm_valid = 1'b0;
  logic [WW-1:0] num = '0;
  logic [1:0]    cd = 2'b00;
  logic [1:0]    o_filt_re, o_filt_wen, o_ifm_re, o_ifm_wen, o_cstart, o_cbusy, o_busy, o_done;
  logic [AW-1:0] o_filt_waddr [2];
  logic [AW-1:0] o_ifm_waddr  [2];
  logic [AW-1:0] o_base       [2];

  int checks = 0, errors = 0;
  int lat = 2, cdcnt[2];
  bit tog = 1'b0, run = 1'b0;
  int filt_n[2], filt_seq[2], ifm_n[2], ifm_seq[2], base_n[2], base_seq[2], done_n[2], busy_n[2];

  item_t plan[2][PMAX];
  int    head[2], tail[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pe_fill_scheduler_if #(.FILT_LEN(FL), .WIN_W(WW)) bus ();
    assign bus.chip_en         = chip_en;
    assign bus.start           = start;
    assign bus.num_windows     = num;
    assign bus.filt_buf_valid  = filt_valid;
    assign bus.ifmap_buf_valid = ifm_valid;
    assign bus.compute_done    = cd[g];
    assign o_filt_re[g]    = bus.filt_buf_read_enable;
    assign o_filt_wen[g]   = bus.filt_pad_wen;
    assign o_filt_waddr[g] = bus.filt_pad_waddr;
    assign o_ifm_re[g]     = bus.ifmap_buf_read_enable;
    assign o_ifm_wen[g]    = bus.ifmap_pad_wen;
    assign o_ifm_waddr[g]  = bus.ifmap_pad_waddr;
    assign o_base[g]       = bus.window_base;
    assign o_cstart[g]     = bus.compute_start;
    assign o_cbusy[g]      = bus.compute_busy;
    assign o_busy[g]       = bus.busy;
    assign o_done[g]       = bus.done;
    pe_fill_scheduler #(.FILT_LEN(FL), .STRIDE(g + 1), .WIN_W(WW)) dut (.clk(clk), .rst(rst), .bus(bus));
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input kind_e k, input int a);
    if (tail[i] < PMAX) begin
      plan[i][tail[i]] = '{kind: k, addr: a, started: 1'b0};
      tail[i]++;
    end
  endtask

  // A job is a fixed list of steps: filter words, window words, windows, done.
  task automatic build(input int i, input int n);
    int s, p;
    s = i + 1;
    p = 0;
    head[i] = 0;
    tail[i] = 0;
    if (n != 0) begin
      for (int a = 0; a < FL; a++) push(i, K_FILT, a);
      for (int a = 0; a < FL; a++) push(i, K_IFM, a);
      push(i, K_CMP, 0);
      for (int w = 1; w < n; w++) begin
        for (int k = 0; k < s; k++) begin
          push(i, K_IFM, p);
          p = (p + 1) % FL;
        end
        push(i, K_CMP, p);
      end
    end
    push(i, K_DONE, 0);
  endtask

  // model advance: retire the head step when its condition holds
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      head = '{0, 0};
      tail = '{0, 0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (head[i] == tail[i]) begin
          if (start) build(i, int'(num));
        end else begin
          case (plan[i][head[i]].kind)
            K_FILT:  if (chip_en && filt_valid) head[i]++;
            K_IFM:   if (chip_en && ifm_valid) head[i]++;
            K_CMP:   if (cd[i]) head[i]++; else plan[i][head[i]].started = 1'b1;
            default: head[i]++;
          endcase
        end
      end
    end
  end

  // per-cycle compare against the model plus logging of observed traffic
  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 2; i++) begin : cmp
        item_t it;
        bit e_busy, e_fx, e_ix, e_cb, e_cs, e_done;
        e_busy = (head[i] != tail[i]);
        if (e_busy) it = plan[i][head[i]];
        else        it = '{kind: K_DONE, addr: 0, started: 1'b0};
        e_fx   = e_busy && (it.kind == K_FILT) && chip_en && filt_valid;
        e_ix   = e_busy && (it.kind == K_IFM) && chip_en && ifm_valid;
        e_cb   = e_busy && (it.kind == K_CMP);
        e_cs   = e_cb && !it.started;
        e_done = e_busy && (it.kind == K_DONE);
        chk($sformatf("busy[%0d]", i), int'(o_busy[i]), int'(e_busy));
        chk($sformatf("filt_re[%0d]", i), int'(o_filt_re[i]), int'(e_fx));
        chk($sformatf("filt_wen[%0d]", i), int'(o_filt_wen[i]), int'(e_fx));
        chk($sformatf("ifmap_re[%0d]", i), int'(o_ifm_re[i]), int'(e_ix));
        chk($sformatf("ifmap_wen[%0d]", i), int'(o_ifm_wen[i]), int'(e_ix));
        chk($sformatf("compute_busy[%0d]", i), int'(o_cbusy[i]), int'(e_cb));
        chk($sformatf("compute_start[%0d]", i), int'(o_cstart[i]), int'(e_cs));
        chk($sformatf("done[%0d]", i), int'(o_done[i]), int'(e_done));
        if (e_fx) chk($sformatf("filt_waddr[%0d]", i), int'(o_filt_waddr[i]), it.addr);
        if (e_ix) chk($sformatf("ifmap_waddr[%0d]", i), int'(o_ifm_waddr[i]), it.addr);
        if (e_cb) chk($sformatf("window_base[%0d]", i), int'(o_base[i]), it.addr);
        if (o_filt_wen[i]) begin filt_n[i]++; filt_seq[i] = filt_seq[i] * 16 + int'(o_filt_waddr[i]); end
        if (o_ifm_wen[i])  begin ifm_n[i]++;  ifm_seq[i]  = ifm_seq[i] * 16 + int'(o_ifm_waddr[i]); end
        if (o_cstart[i])   begin base_n[i]++; base_seq[i] = base_seq[i] * 16 + int'(o_base[i]); end
        if (o_done[i]) done_n[i]++;
        if (o_busy[i]) busy_n[i]++;
      end
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      filt_n[i] = 0; filt_seq[i] = 0; ifm_n[i] = 0; ifm_seq[i] = 0;
      base_n[i] = 0; base_seq[i] = 0; done_n[i] = 0; busy_n[i] = 0;
    end
  endtask

  // one clock; compute unit answers after `lat` busy cycles
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (o_cbusy[i]) begin
        cd[i] = (cdcnt[i] >= lat);
        cdcnt[i]++;
      end else begin
        cd[i] = 1'b0;
        cdcnt[i] = 0;
      end
    end
    if (tog) filt_valid = ~filt_valid;
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1;
    num = WW'(n);
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int k;
    k = 0;
    while ((o_busy != 2'b00) && (k < bound)) begin
      step();
      k++;
    end
    chk({nm, "_idle_timeout"}, int'(o_busy != 2'b00), 0);
    step();
  endtask

  task automatic chk_job(input string nm, input int i, input int fn, input int fs, input int in_, input int is,
                         input int bn, input int bs);
    chk({nm, "_filt_pops"}, filt_n[i], fn);
    chk({nm, "_filt_addrs"}, filt_seq[i], fs);
    chk({nm, "_ifmap_pops"}, ifm_n[i], in_);
    chk({nm, "_ifmap_addrs"}, ifm_seq[i], is);
    chk({nm, "_windows"}, base_n[i], bn);
    chk({nm, "_bases"}, base_seq[i], bs);
    chk({nm, "_done_pulses"}, done_n[i], 1);
  endtask

  initial begin
    int k;
    clear_logs();
    repeat (3) step();
    run = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_flags", int'({o_busy, o_cbusy, o_done, o_cstart, o_filt_re, o_filt_wen, o_ifm_re, o_ifm_wen}), 0);
    chk("reset_addrs", int'({o_filt_waddr[0], o_ifm_waddr[0], o_base[0], o_filt_waddr[1], o_ifm_waddr[1], o_base[1]}), 0);

    // basic job, all valids high
    chip_en = 1'b1; filt_valid = 1'b1; ifm_valid = 1'b1; lat = 2;
    step(); clear_logs();
    pulse_start(3);
    wait_idle("job3", 100);
    chk_job("job3_s1", 0, 4, 32'h0123, 6, 32'h012301, 3, 32'h012);
    chk_job("job3_s2", 1, 4, 32'h0123, 8, 32'h01230123, 3, 32'h020);

    // filter valid toggling, compute done on first compute cycle
    clear_logs(); tog = 1'b1; lat = 0;
    pulse_start(3);
    wait_idle("toggle", 100);
    tog = 1'b0; filt_valid = 1'b1;
    chk_job("toggle_s1", 0, 4, 32'h0123, 6, 32'h012301, 3, 32'h012);

    // stride 2, two windows
    clear_logs(); lat = 1;
    pulse_start(2);
    wait_idle("job2", 100);
    chk_job("job2_s2", 1, 4, 32'h0123, 6, 32'h012301, 2, 32'h02);
    chk_job("job2_s1", 0, 4, 32'h0123, 5, 32'h01230, 2, 32'h01);

    // chip_en low for 5 cycles in the middle of the window fill
    clear_logs();
    pulse_start(1);
    k = 0;
    while ((ifm_n[0] < 2) && (k < 40)) begin step(); k++; end
    chk("gate_reach_timeout", int'(ifm_n[0] < 2), 0);
    chip_en = 1'b0;
    repeat (5) step();
    chk("gate_frozen_pops", ifm_n[0], 2);
    chk("gate_frozen_ptr", int'(o_ifm_waddr[0]), 2);
    chip_en = 1'b1;
    wait_idle("gate", 100);
    chk_job("gate_s1", 0, 4, 32'h0123, 4, 32'h0123, 1, 32'h0);

    // zero-window job, then start held high while busy
    clear_logs();
    pulse_start(0);
    wait_idle("zero", 20);
    chk("zero_busy_cycles", busy_n[0], 1);
    chk("zero_done", done_n[0], 1);
    chk("zero_pops", filt_n[0] + ifm_n[0] + filt_n[1] + ifm_n[1], 0);
    clear_logs();
    start = 1'b1; num = 8'd2;
    step();
    num = 8'd5;
    repeat (10) step();
    start = 1'b0;
    wait_idle("held", 100);
    chk("held_windows", base_n[0], 2);
    chk("held_done", done_n[0], 1);

    // reset while sliding, then a fresh job
    clear_logs(); lat = 2;
    pulse_start(3);
    k = 0;
    while (!((base_n[0] == 1) && (o_cbusy[0] == 1'b0)) && (k < 60)) begin step(); k++; end
    chk("slide_reach_timeout", int'(k >= 60), 0);
    chk("slide_is_writing", int'(o_ifm_wen[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_flags", int'({o_busy, o_cbusy, o_done, o_cstart, o_filt_re, o_filt_wen, o_ifm_re, o_ifm_wen}), 0);
    chk("rst_addrs", int'({o_filt_waddr[0], o_ifm_waddr[0], o_base[0]}), 0);
    step();
    rst = 1'b0;
    step(); clear_logs();
    pulse_start(1);
    wait_idle("after_rst", 100);
    chk_job("after_rst_s1", 0, 4, 32'h0123, 4, 32'h0123, 1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
